// File: rtl/moore_seq_pkg.sv
// Shared helpers for the parametrised Moore sequence detector: state-width
// calculation and the prefix/suffix next-state function used to build the
// transition table at elaboration time.
package moore_seq_pkg;

  localparam int S_IDLE = 0;

  // Number of bits needed to encode v distinct values.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Single bit of a vector selected by a run-time integer index.
  function automatic logic bit_at(input logic [31:0] v, input int idx);
    logic [31:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  // Next state after seeing bit b in state 'state'. The candidate string is
  // the first i pattern bits followed by b; the result is the longest k that
  // is both a suffix of the candidate and a prefix of the pattern, capped at
  // len so that from MATCH only a proper suffix can survive.
  function automatic int calc_next(input logic [15:0] pattern, input int len,
                                   input int overlap, input int state,
                                   input int b);
    logic [31:0] cand;
    logic [31:0] pat;
    int          i;
    int          kmax;
    int          best;
    logic        ok;
    pat  = {16'h0000, pattern};
    cand = '0;
    if (state >= len) i = (overlap != 0) ? len : 0;
    else              i = state;
    for (int j = 0; j < i; j++)
      if (bit_at(pat, len - 1 - j)) cand = cand | (32'd1 << j);
    if (b != 0) cand = cand | (32'd1 << i);
    kmax = (i + 1 < len) ? i + 1 : len;
    best = 0;
    for (int k = 1; k <= kmax; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (bit_at(cand, i + 1 - k + j) != bit_at(pat, len - 1 - j)) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

endpackage

// File: rtl/moore_seq_next.sv
// Combinational next-state lookup for the sequence detector. The whole
// transition table is a constant fixed at elaboration; at run time this is
// only a table read indexed by {state, din}.
module moore_seq_next
  import moore_seq_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter int                     OVERLAP     = 1,
  localparam int                    SW          = clog2(PATTERN_LEN + 1)
) (
  input  logic [SW-1:0] state,
  input  logic          din,
  output logic [SW-1:0] next_state
);

  localparam int TBL = 2 ** (SW + 1);

  logic [SW-1:0] tbl [TBL];

  // One table entry per {state, bit}; unreachable state codes fall back to idle.
  for (genvar e = 0; e < TBL; e++) begin : g_tbl
    localparam int ST = e / 2;
    localparam int NX = (ST <= PATTERN_LEN) ?
                        calc_next(16'(PATTERN), PATTERN_LEN, OVERLAP, ST, e % 2) :
                        S_IDLE;
    assign tbl[e] = SW'(NX);
  end

  assign next_state = tbl[{state, din}];

endmodule

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial sequence detector: state register, saturating
// match counter and registered MATCH decode around the table-driven
// next-state block.
module moore_seq_detector_param
  import moore_seq_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter int                     OVERLAP     = 1,
  parameter int                     CNT_W       = 8,
  localparam int                    SW          = clog2(PATTERN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in,
  output logic             out,
  output logic [SW-1:0]    state_o,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [SW-1:0]    ST_IDLE  = SW'(S_IDLE);
  localparam logic [SW-1:0]    ST_MATCH = SW'(PATTERN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [SW-1:0] state;
  logic [SW-1:0] nxt;

  moore_seq_next #(
    .PATTERN_LEN (PATTERN_LEN),
    .PATTERN     (PATTERN),
    .OVERLAP     (OVERLAP)
  ) u_next (
    .state      (state),
    .din        (in),
    .next_state (nxt)
  );

  // Advance on qualified bits only; clear beats data, and out tracks MATCH of the new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      out         <= 1'b0;
      match_count <= '0;
    end else if (clr) begin
      state       <= ST_IDLE;
      out         <= 1'b0;
      match_count <= '0;
    end else if (in_valid) begin
      state <= nxt;
      out   <= (nxt == ST_MATCH);
      if (nxt == ST_MATCH && match_count != CNT_MAX)
        match_count <= match_count + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Self-checking bench: three detector instances (overlap 1011, non-overlap
// 1011, saturating 2-bit counter on pattern 11) share one stimulus stream and
// are compared against a history-based reference model.
module tb_moore_seq_detector_param;

  logic clk;
  logic rst;
  logic clr;
  logic in_valid;
  logic in;

  logic       a_out;
  logic [2:0] a_state;
  logic [7:0] a_cnt;
  logic       b_out;
  logic [2:0] b_state;
  logic [7:0] b_cnt;
  logic       c_out;
  logic [1:0] c_state;
  logic [1:0] c_cnt;

  int checks;
  int errors;

  // Reference model: per instance, the recent bit history plus parameters.
  int          m_n    [3];
  int          m_ov   [3];
  int          m_cmax [3];
  logic [15:0] m_pat  [3];
  logic [31:0] m_hist [3];
  int          m_hlen [3];
  int          m_state[3];
  int          m_cnt  [3];

  typedef struct {
    logic v;
    logic b;
    int   a_state;
    int   a_cnt;
    int   b_state;
    int   b_cnt;
  } vec_t;

  vec_t tbl[7];

  moore_seq_detector_param #(
    .PATTERN_LEN (4), .PATTERN (4'b1011), .OVERLAP (1), .CNT_W (8)
  ) dut_a (
    .clk (clk), .rst (rst), .clr (clr), .in_valid (in_valid), .in (in),
    .out (a_out), .state_o (a_state), .match_count (a_cnt)
  );

  moore_seq_detector_param #(
    .PATTERN_LEN (4), .PATTERN (4'b1011), .OVERLAP (0), .CNT_W (8)
  ) dut_b (
    .clk (clk), .rst (rst), .clr (clr), .in_valid (in_valid), .in (in),
    .out (b_out), .state_o (b_state), .match_count (b_cnt)
  );

  moore_seq_detector_param #(
    .PATTERN_LEN (2), .PATTERN (2'b11), .OVERLAP (1), .CNT_W (2)
  ) dut_c (
    .clk (clk), .rst (rst), .clr (clr), .in_valid (in_valid), .in (in),
    .out (c_out), .state_o (c_state), .match_count (c_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic hbit(input logic [31:0] v, input int idx);
    logic [31:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  // Longest k<=n such that the newest k history bits spell the first k pattern bits.
  function automatic int longest(input logic [31:0] hist, input int hlen,
                                 input logic [15:0] pat, input int n);
    int   best;
    logic ok;
    logic [31:0] p;
    p = {16'h0000, pat};
    best = 0;
    for (int k = 1; k <= n; k++) begin
      if (k <= hlen) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (hbit(hist, k - 1 - j) != hbit(p, n - 1 - j)) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 3; m++) begin
      m_hist[m]  = '0;
      m_hlen[m]  = 0;
      m_state[m] = 0;
      m_cnt[m]   = 0;
    end
  endtask

  task automatic model_update(input logic c, input logic v, input logic b);
    if (c) begin
      model_clear();
    end else if (v) begin
      for (int m = 0; m < 3; m++) begin
        m_hist[m] = {m_hist[m][30:0], b};
        if (m_hlen[m] < 32) m_hlen[m] = m_hlen[m] + 1;
        m_state[m] = longest(m_hist[m], m_hlen[m], m_pat[m], m_n[m]);
        if (m_state[m] == m_n[m]) begin
          if (m_cnt[m] < m_cmax[m]) m_cnt[m] = m_cnt[m] + 1;
          if (m_ov[m] == 0) m_hlen[m] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_output();
    check("A out",   int'(a_out),   int'(m_state[0] == m_n[0]));
    check("A state", int'(a_state), m_state[0]);
    check("A count", int'(a_cnt),   m_cnt[0]);
    check("B out",   int'(b_out),   int'(m_state[1] == m_n[1]));
    check("B state", int'(b_state), m_state[1]);
    check("B count", int'(b_cnt),   m_cnt[1]);
    check("C out",   int'(c_out),   int'(m_state[2] == m_n[2]));
    check("C state", int'(c_state), m_state[2]);
    check("C count", int'(c_cnt),   m_cnt[2]);
  endtask

  // Called at a falling edge: drive, let the rising edge sample, return at the next falling edge.
  task automatic apply_stimulus(input logic c, input logic v, input logic b);
    clr      = c;
    in_valid = v;
    in       = b;
    @(posedge clk);
    model_update(c, v, b);
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    check("A out after rst", int'(a_out), 0);
    check("A state after rst", int'(a_state), 0);
    check("A count after rst", int'(a_cnt), 0);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in       = 1'b0;

    m_n[0] = 4; m_ov[0] = 1; m_cmax[0] = 255; m_pat[0] = 16'b1011;
    m_n[1] = 4; m_ov[1] = 0; m_cmax[1] = 255; m_pat[1] = 16'b1011;
    m_n[2] = 2; m_ov[2] = 1; m_cmax[2] = 3;   m_pat[2] = 16'b11;
    model_clear();

    // Stream 1,0,1,1,0,1,1 with hand-derived states for overlap and non-overlap.
    tbl[0] = '{1'b1, 1'b1, 1, 0, 1, 0};
    tbl[1] = '{1'b1, 1'b0, 2, 0, 2, 0};
    tbl[2] = '{1'b1, 1'b1, 3, 0, 3, 0};
    tbl[3] = '{1'b1, 1'b1, 4, 1, 4, 1};
    tbl[4] = '{1'b1, 1'b0, 2, 1, 0, 1};
    tbl[5] = '{1'b1, 1'b1, 3, 1, 1, 1};
    tbl[6] = '{1'b1, 1'b1, 4, 2, 1, 1};

    // Reset values.
    do_reset();
    check("reset A out", int'(a_out), 0);
    check("reset A state", int'(a_state), 0);
    check("reset A count", int'(a_cnt), 0);
    check_output();

    // Table-driven main stream.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b0, tbl[i].v, tbl[i].b);
      check($sformatf("tbl%0d A state", i), int'(a_state), tbl[i].a_state);
      check($sformatf("tbl%0d A out", i),   int'(a_out),   int'(tbl[i].a_state == 4));
      check($sformatf("tbl%0d A count", i), int'(a_cnt),   tbl[i].a_cnt);
      check($sformatf("tbl%0d B state", i), int'(b_state), tbl[i].b_state);
      check($sformatf("tbl%0d B out", i),   int'(b_out),   int'(tbl[i].b_state == 4));
      check($sformatf("tbl%0d B count", i), int'(b_cnt),   tbl[i].b_cnt);
      check_output();
    end

    // Qualifier: invalid cycles with a toggling input must not move the state.
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b0, logic'(i % 2));
      check("hold A state", int'(a_state), 3);
      check("hold A out", int'(a_out), 0);
      check_output();
    end
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check("after hold A out", int'(a_out), 1);
    check("after hold A count", int'(a_cnt), 1);
    check_output();

    // MATCH holds out=1 while in_valid is low.
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check("idle at match A out", int'(a_out), 1);

    // Saturation of the 2-bit counter on pattern 11.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b1);
      check("sat C count", int'(c_cnt), (i >= 4) ? 3 : i - 1);
      check("sat C out", int'(c_out), int'(i >= 2));
      check_output();
    end

    // clr wins over a final valid bit.
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check("clr A state", int'(a_state), 0);
    check("clr A out", int'(a_out), 0);
    check("clr A count", int'(a_cnt), 0);
    check_output();

    // Async reset in S3 and in MATCH takes effect before the next edge.
    apply_stimulus(1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check("pre-rst A state", int'(a_state), 3);
    rst_pulse();
    @(negedge clk);
    check_output();
    apply_stimulus(1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check("pre-rst A out", int'(a_out), 1);
    rst_pulse();
    @(negedge clk);
    check_output();

    // Randomised stream against the reference model.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(logic'($urandom_range(0, 29) == 0),
                     logic'($urandom_range(0, 3) != 0),
                     logic'($urandom_range(0, 1)));
      check_output();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
